// File: rtl/park_gate_ctrl.sv
// Entry-gate controller: password check, timed gate opening, wrong-password
// lockout with alarm, and an occupancy counter with capacity limit.
//
// state   | meaning
// IDLE    | gate closed, waiting for a car at the front sensor
// WAIT_PW | car present, waiting for a password strobe
// OPEN    | gate open until back sensor or open timeout
// LOCKED  | too many wrong passwords, alarm raised for a fixed time
module park_gate_ctrl #(
   parameter int          PW_W        = 8,
   parameter int unsigned PASSWORD    = 253,
   parameter int          MAX_TRIES   = 3,
   parameter int          LOCK_CYCLES = 1000,
   parameter int          OPEN_CYCLES = 5000,
   parameter int          CAPACITY    = 16,
   parameter int          CNT_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             car_i,
   input  logic             fr_sens_i,
   input  logic             bk_sens_i,
   input  logic [PW_W-1:0]  pswd_i,
   input  logic             pswd_vld_i,
   input  logic             exit_sens_i,
   output logic             gate_o,
   output logic             alarm_o,
   output logic             pw_err_o,
   output logic             full_o,
   output logic [CNT_W-1:0] occupancy_o
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT_PW = 2'd1;
   localparam logic [1:0] OPEN    = 2'd2;
   localparam logic [1:0] LOCKED  = 2'd3;

   localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int TRY_W   = $clog2(MAX_TRIES + 1);

   localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
   localparam logic [TRY_W-1:0] TRY_LIM   = TRY_W'(MAX_TRIES);
   localparam logic [CNT_W-1:0] CAP_V     = CNT_W'(CAPACITY);
   localparam logic [PW_W-1:0]  PW_V      = PW_W'(PASSWORD);

   logic [1:0]       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             gate_q, alarm_q, pw_err_q, pw_err_d;
   logic             occ_inc, occ_inc_ok, occ_dec;

   assign tries_inc = tries_q + TRY_W'(1);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      tries_d  = tries_q;
      pw_err_d = 1'b0;
      occ_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (car_i && fr_sens_i && !full_o) begin
               state_d = WAIT_PW;
               tries_d = '0;
            end
         end
         WAIT_PW: begin
            // Losing the car outranks any password strobe in the same cycle.
            if (!car_i || !fr_sens_i) begin
               state_d = IDLE;
               tries_d = '0;
            end else if (pswd_vld_i) begin
               if (pswd_i == PW_V) begin
                  state_d = OPEN;
                  timer_d = OPEN_LOAD;
               end else begin
                  pw_err_d = 1'b1;
                  tries_d  = tries_inc;
                  if (tries_inc == TRY_LIM) begin
                     state_d = LOCKED;
                     timer_d = LOCK_LOAD;
                  end
               end
            end
         end
         OPEN: begin
            if (!car_i) begin
               state_d = IDLE;
            end else if (bk_sens_i) begin
               state_d = IDLE;
               occ_inc = 1'b1;
            end else if (timer_q == '0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         LOCKED: begin
            if (timer_q == '0) begin
               state_d = IDLE;
               tries_d = '0;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign occ_inc_ok = occ_inc && (occ_q != CAP_V);
   assign occ_dec    = exit_sens_i && (occ_q != '0);

   always_comb begin
      occ_d = occ_q;
      if (occ_inc_ok && !occ_dec)      occ_d = occ_q + CNT_W'(1);
      else if (!occ_inc_ok && occ_dec) occ_d = occ_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         tries_q  <= '0;
         occ_q    <= '0;
         gate_q   <= 1'b0;
         alarm_q  <= 1'b0;
         pw_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         tries_q  <= tries_d;
         occ_q    <= occ_d;
         gate_q   <= (state_d == OPEN);
         alarm_q  <= (state_d == LOCKED);
         pw_err_q <= pw_err_d;
      end
   end

   assign gate_o      = gate_q;
   assign alarm_o     = alarm_q;
   assign pw_err_o    = pw_err_q;
   assign occupancy_o = occ_q;
   assign full_o      = (occ_q == CAP_V);

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Bench for park_gate_ctrl (CAPACITY=2): per-cycle expected outputs go
// through a scoreboard queue and are compared after each rising edge.
module tb_park_gate_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       car, fr, bk, vld, ex;
   logic [7:0] pw;
   logic       gate, alarm, pw_err, full;
   logic [4:0] occ;

   typedef struct {
      string      tag;
      logic       g, a, p, f;
      logic [4:0] o;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   park_gate_ctrl #(
      .PW_W(8), .PASSWORD(253), .MAX_TRIES(3), .LOCK_CYCLES(1000),
      .OPEN_CYCLES(5000), .CAPACITY(2), .CNT_W(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .car_i(car), .fr_sens_i(fr), .bk_sens_i(bk),
      .pswd_i(pw), .pswd_vld_i(vld), .exit_sens_i(ex),
      .gate_o(gate), .alarm_o(alarm), .pw_err_o(pw_err), .full_o(full),
      .occupancy_o(occ)
   );

   task automatic chk_val(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Push the outputs expected after the next edge, clock, then pop and compare.
   task automatic tick(input string tag, input logic g, input logic a,
                       input logic p, input logic f, input int o);
      exp_t e, r;
      e.tag = tag; e.g = g; e.a = a; e.p = p; e.f = f; e.o = 5'(o);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      r = sb_q.pop_front();
      chk_val({r.tag, ".gate"},   int'(gate),   int'(r.g));
      chk_val({r.tag, ".alarm"},  int'(alarm),  int'(r.a));
      chk_val({r.tag, ".pw_err"}, int'(pw_err), int'(r.p));
      chk_val({r.tag, ".full"},   int'(full),   int'(r.f));
      chk_val({r.tag, ".occ"},    int'(occ),    int'(r.o));
   endtask

   initial begin
      rst_n = 1'b0; car = 0; fr = 0; bk = 0; vld = 0; ex = 0; pw = 8'd0;
      #2;
      chk_val("rst.gate", int'(gate), 0);
      chk_val("rst.alarm", int'(alarm), 0);
      chk_val("rst.pw_err", int'(pw_err), 0);
      chk_val("rst.full", int'(full), 0);
      chk_val("rst.occ", int'(occ), 0);
      #8 rst_n = 1'b1;
      tick("idle", 0, 0, 0, 0, 0);

      ex = 1; tick("exit_at_zero", 0, 0, 0, 0, 0); ex = 0;

      // Normal entry
      car = 1; fr = 1; tick("entry1_wait", 0, 0, 0, 0, 0);
      pw = 8'd253; vld = 1; tick("entry1_open", 1, 0, 0, 0, 0); vld = 0;
      tick("entry1_hold", 1, 0, 0, 0, 0);
      bk = 1; fr = 0; tick("entry1_pass", 0, 0, 0, 0, 1); bk = 0;

      // bk_sens and exit_sens together
      fr = 1; tick("entry2_wait", 0, 0, 0, 0, 1);
      vld = 1; tick("entry2_open", 1, 0, 0, 0, 1); vld = 0;
      bk = 1; ex = 1; fr = 0; tick("simul_inc_dec", 0, 0, 0, 0, 1); bk = 0; ex = 0;

      // Fill to capacity
      fr = 1; tick("entry3_wait", 0, 0, 0, 0, 1);
      vld = 1; tick("entry3_open", 1, 0, 0, 0, 1); vld = 0;
      bk = 1; fr = 0; tick("entry3_pass", 0, 0, 0, 1, 2); bk = 0;
      fr = 1; tick("full_idle0", 0, 0, 0, 1, 2);
      vld = 1; tick("full_idle1", 0, 0, 0, 1, 2); vld = 0;
      tick("full_idle2", 0, 0, 0, 1, 2);
      ex = 1; tick("full_exit", 0, 0, 0, 0, 1); ex = 0;
      tick("entry4_wait", 0, 0, 0, 0, 1);
      vld = 1; tick("entry4_open", 1, 0, 0, 0, 1); vld = 0;
      bk = 1; fr = 0; tick("entry4_pass", 0, 0, 0, 1, 2); bk = 0;
      ex = 1; tick("exit_dec", 0, 0, 0, 0, 1); ex = 0;

      // Lockout
      fr = 1; tick("lock_wait", 0, 0, 0, 0, 1);
      pw = 8'd12;
      vld = 1; tick("bad_pw1", 0, 0, 1, 0, 1); vld = 0;
      tick("bad_gap1", 0, 0, 0, 0, 1);
      vld = 1; tick("bad_pw2", 0, 0, 1, 0, 1); vld = 0;
      tick("bad_gap2", 0, 0, 0, 0, 1);
      vld = 1; tick("bad_pw3", 0, 1, 1, 0, 1); vld = 0;
      for (int i = 1; i < 1000; i++) begin
         pw  = (i == 10) ? 8'd253 : 8'd12;
         vld = (i == 10);
         ex  = (i == 20);
         tick("alarm_on", 0, 1, 0, 0, (i >= 20) ? 0 : 1);
      end
      vld = 0; ex = 0; pw = 8'd253; fr = 0;
      tick("alarm_off", 0, 0, 0, 0, 0);
      tick("after_lock", 0, 0, 0, 0, 0);

      // Open timeout
      fr = 1; tick("to_wait", 0, 0, 0, 0, 0);
      vld = 1; tick("to_open", 1, 0, 0, 0, 0); vld = 0; fr = 0;
      for (int i = 1; i < 5000; i++) tick("to_hold", 1, 0, 0, 0, 0);
      tick("to_close", 0, 0, 0, 0, 0);
      bk = 1; tick("bk_in_idle", 0, 0, 0, 0, 0); bk = 0;

      // car drop while open: no count even with bk_sens
      fr = 1; tick("drop_wait", 0, 0, 0, 0, 0);
      vld = 1; tick("drop_open", 1, 0, 0, 0, 0); vld = 0;
      car = 0; bk = 1; tick("drop_close", 0, 0, 0, 0, 0); bk = 0; car = 1;

      // Reset mid-OPEN with nonzero occupancy
      tick("rs_wait", 0, 0, 0, 0, 0);
      vld = 1; tick("rs_open", 1, 0, 0, 0, 0); vld = 0;
      bk = 1; fr = 0; tick("rs_pass", 0, 0, 0, 0, 1); bk = 0;
      fr = 1; tick("rs_wait2", 0, 0, 0, 0, 1);
      vld = 1; tick("rs_open2", 1, 0, 0, 0, 1); vld = 0; fr = 0;
      #1 rst_n = 1'b0;
      #1;
      chk_val("async_rst.gate", int'(gate), 0);
      chk_val("async_rst.occ", int'(occ), 0);
      #2 rst_n = 1'b1;
      tick("post_rst", 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/park_gate_ctrl.md
Name: park_gate_ctrl

Overview:
- Parametrised entry-gate controller for the car-park assignment line.
- Detects an arriving car on the front sensor and checks a presented password.
- Opens the gate until the car clears the back sensor or a timeout expires.
- Adds a wrong-password retry limit with timed lockout/alarm, an occupancy counter with capacity limit, and an exit-lane decrement input.

Parameters:
PW_W, 8, password bus width in bits
PASSWORD, 253, expected password value (PW_W bits)
MAX_TRIES, 3, wrong attempts allowed before lockout (>=1)
LOCK_CYCLES, 1000, lockout duration in clk cycles (>=1)
OPEN_CYCLES, 5000, maximum gate-open time in clk cycles (>=1)
CAPACITY, 16, maximum parked cars (>=1)
CNT_W, 5, occupancy counter width; must hold CAPACITY

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
car  in  1  controller enable; 0 forces return to IDLE
fr_sens  in  1  front sensor, car waiting at gate
bk_sens  in  1  back sensor, car has passed the gate
pswd  in  PW_W  password value
pswd_vld  in  1  one-cycle strobe; pswd sampled when high
exit_sens  in  1  one-cycle pulse, a car left through the exit lane
gate  out  1  1 = gate open
alarm  out  1  1 = lockout active
pw_err  out  1  one-cycle pulse on wrong password
full  out  1  occupancy == CAPACITY
occupancy  out  CNT_W  cars currently parked

Behaviour:
- All state and outputs are registered.
- Reset (rst_n low, asynchronous) sets state IDLE, gate=0, alarm=0, pw_err=0, occupancy=0, full=0, tries=0, timer=0.
- States: IDLE, WAIT_PW, OPEN, LOCKED. gate=1 only in OPEN. alarm=1 only in LOCKED.
- IDLE:
  - car&&fr_sens&&!full -> WAIT_PW next cycle; tries cleared.
  - If full, remain in IDLE; the password is never requested.
- WAIT_PW:
  - pswd_vld && pswd==PASSWORD -> OPEN; timer loaded with OPEN_CYCLES-1. gate rises the cycle after the strobe (1-cycle latency).
  - pswd_vld && mismatch -> pw_err=1 for one cycle and tries+1.
  - If the new tries==MAX_TRIES -> LOCKED; timer loaded with LOCK_CYCLES-1.
  - !fr_sens (car drove off) -> IDLE; tries cleared.
  - pswd_vld without fr_sens in the same cycle: the fr_sens exit takes priority and the strobe is ignored.
- OPEN:
  - bk_sens -> IDLE; occupancy+1.
  - Else timer==0 -> IDLE with no increment (timeout).
  - Else timer-1.
  - bk_sens on the last timer cycle counts as passage.
- LOCKED:
  - Ignores fr_sens and pswd_vld.
  - timer==0 -> IDLE; tries cleared. Else timer-1.
  - Total alarm duration is exactly LOCK_CYCLES cycles.
- car==0 in any state except LOCKED -> IDLE next cycle; gate drops. LOCKED always runs to completion.
- Occupancy rules:
  - exit_sens decrements when occupancy>0; it is ignored at 0 (no underflow).
  - Increment never exceeds CAPACITY; the full gate in IDLE guarantees this, and the counter still saturates.
  - Simultaneous increment and decrement in one cycle -> occupancy unchanged.
  - full is combinationally derived from the registered occupancy; it is valid the same cycle occupancy updates.
- exit_sens is processed in every state, including LOCKED.

Test Plan:
- Reset mid-OPEN (rst_n low for 1 cycle while gate=1) -> gate=0, occupancy=0, state IDLE immediately, without waiting for a clock edge.
- Normal entry: car=1, fr_sens=1; one cycle later pswd=253 with pswd_vld -> gate=1 on the next cycle; bk_sens pulse -> gate=0 next cycle, occupancy=1.
- Lockout: pswd=12 strobed 3 times -> 3 pw_err pulses; after the 3rd, alarm=1 for exactly 1000 cycles; a pswd=253 strobe during the alarm is ignored; then IDLE.
- Timeout: correct password with bk_sens held 0 -> gate=1 for exactly 5000 cycles, then 0; occupancy unchanged.
- Capacity: CAPACITY=2, two successful entries -> full=1; a third car at fr_sens stays in IDLE with gate=0; an exit_sens pulse -> occupancy=1, full=0, and the third car proceeds.
- Simultaneous events: bk_sens and exit_sens in the same cycle with occupancy=1 -> occupancy stays 1. exit_sens at occupancy=0 -> stays 0.
